// File: rtl/decision_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decision_pkg                                               |
// | Description : Class codes, class count and vote-FSM state encodings      |
// |               shared by the decision_vote block.                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package decision_pkg;

  localparam logic [7:0] CLASS_NONE = 8'h00;
  localparam logic [7:0] CLASS_Y1   = 8'h01;
  localparam logic [7:0] CLASS_Y2   = 8'h02;
  localparam logic [7:0] CLASS_Y3   = 8'h03;
  localparam logic [7:0] CLASS_Y4   = 8'h04;
  localparam int         NUM_CLASS  = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  function automatic logic is_valid_class(input logic [7:0] code);
    return (code >= CLASS_Y1) && (code <= CLASS_Y4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/class_vote_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : class_vote_cnt                                             |
// | Description : Per-class vote counter with synchronous clear priority.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module class_vote_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/decision_vote.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decision_vote                                              |
// | Description : Collects WINDOW class decisions, majority-votes them and   |
// |               offers the result on a valid/ready handshake.              |
// |               Optional macro VOTE_ERR_CNT_EN adds err_cnt_o, a           |
// |               saturating count of invalid samples since reset.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module decision_vote
  import decision_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [7:0]  y_i,
  input  logic        y_valid_i,
  output logic        start_o,
  output logic [7:0]  vote_o,
  output logic        vote_valid_o,
  input  logic        vote_ready_i,
`ifdef VOTE_ERR_CNT_EN
  output logic [15:0] err_cnt_o,
`endif
  output logic        err_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);

  if ((WINDOW < 1) || (WINDOW > ((2 ** CNT_W) - 1))) begin : g_bad_window
    $error("decision_vote: WINDOW out of range for CNT_W");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_samp_cnt;
  logic             r_err_flag;
  logic [7:0]       r_vote;
  logic             r_vote_valid;
  logic             r_err;

  logic             w_take;
  logic             w_code_ok;
  logic             w_abort;
  logic             w_hs;
  logic             w_clr;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt [NUM_CLASS];
  logic [7:0]       w_best;
  logic [CNT_W-1:0] w_best_cnt;

  // Abort has priority over everything else in COLLECT, including the final sample.
  assign w_take    = (r_state == ST_COLLECT) && en_i && y_valid_i;
  assign w_code_ok = is_valid_class(y_i);
  assign w_abort   = (r_state == ST_COLLECT) && !en_i;
  assign w_hs      = (r_state == ST_HOLD) && vote_ready_i;
  assign w_clr     = w_abort || w_hs;
  assign w_last    = w_take && (r_samp_cnt == C_LAST);

  for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_cls
    class_vote_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_clr),
      .i_inc (w_take && (y_i == (CLASS_Y1 + 8'(gi)))),
      .o_cnt (w_cnt[gi])
    );
  end

  // Strict compare keeps the lowest code on ties; all-zero leaves CLASS_NONE.
  always_comb begin
    w_best     = CLASS_NONE;
    w_best_cnt = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (w_cnt[k] > w_best_cnt) begin
        w_best_cnt = w_cnt[k];
        w_best     = CLASS_Y1 + 8'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (en_i) w_state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (!en_i)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: w_state_nxt = ST_HOLD;
      ST_HOLD:    if (vote_ready_i) w_state_nxt = en_i ? ST_COLLECT : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_samp_cnt   <= '0;
      r_err_flag   <= 1'b0;
      r_vote       <= CLASS_NONE;
      r_vote_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_samp_cnt <= '0;
        r_err_flag <= 1'b0;
      end else if (w_take) begin
        r_samp_cnt <= r_samp_cnt + 1'b1;
        if (!w_code_ok) r_err_flag <= 1'b1;
      end
      if (r_state == ST_RESOLVE) begin
        r_vote       <= w_best;
        r_err        <= r_err_flag;
        r_vote_valid <= 1'b1;
      end else if (w_hs) begin
        r_vote_valid <= 1'b0;
      end
    end
  end

`ifdef VOTE_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= 16'h0000;
    end else if (w_take && !w_code_ok && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'h0001;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign start_o      = (r_state == ST_COLLECT);
  assign vote_o       = r_vote;
  assign vote_valid_o = r_vote_valid;
  assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_decision_vote.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decision_vote                                           |
// | Description : Scoreboard bench for decision_vote (WINDOW=4).             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_decision_vote;

  localparam int WINDOW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_i;
  logic [7:0]  y_i;
  logic        y_valid_i;
  logic        start_o;
  logic [7:0]  vote_o;
  logic        vote_valid_o;
  logic        vote_ready_i;
  logic        err_o;
`ifdef VOTE_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  decision_vote #(
    .WINDOW (WINDOW),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_i),
    .y_i          (y_i),
    .y_valid_i    (y_valid_i),
    .start_o      (start_o),
    .vote_o       (vote_o),
    .vote_valid_o (vote_valid_o),
    .vote_ready_i (vote_ready_i),
`ifdef VOTE_ERR_CNT_EN
    .err_cnt_o    (err_cnt_o),
`endif
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] vote;
    logic       err;
    int         err_cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] m_win[$];
  int         m_phase = 0;   // 0 idle, 1 collecting, 2 resolving, 3 offering
  int         m_err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Majority of the window by plain counting; lowest code wins ties.
  function automatic exp_t judge();
    exp_t r;
    int   cnt[5];
    int   best;
    for (int c = 0; c < 5; c++) cnt[c] = 0;
    r.err = 1'b0;
    foreach (m_win[i]) begin
      if (m_win[i] >= 8'd1 && m_win[i] <= 8'd4) cnt[m_win[i]]++;
      else r.err = 1'b1;
    end
    best = 0;
    for (int c = 1; c <= 4; c++) if (cnt[c] > cnt[best]) best = c;
    r.vote    = 8'(best);
    r.err_cnt = m_err_cnt;
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase   = 0;
      m_err_cnt = 0;
      m_win.delete();
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (en_i) m_phase = 1;
        1: begin
          if (!en_i) begin
            m_phase = 0;
            m_win.delete();
          end else if (y_valid_i) begin
            m_win.push_back(y_i);
            if (!(y_i >= 8'd1 && y_i <= 8'd4) && m_err_cnt < 65535) m_err_cnt++;
            if (m_win.size() == WINDOW) begin
              exp_q.push_back(judge());
              m_phase = 2;
            end
          end
        end
        2: m_phase = 3;
        default: if (vote_ready_i) begin
          m_win.delete();
          m_phase = en_i ? 1 : 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("start_o", start_o, m_phase == 1);
      chk("vote_valid_o", vote_valid_o, m_phase == 3);
      if (vote_valid_o && vote_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL vote_unexpected: got vote %0h with no vote pending", vote_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("vote_o", vote_o, mon_e.vote);
          chk("err_o", err_o, mon_e.err);
`ifdef VOTE_ERR_CNT_EN
          chk("err_cnt_o", err_cnt_o, mon_e.err_cnt);
`endif
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] y);
    y_valid_i = v;
    y_i       = y;
    @(posedge clk);
    #1;
  endtask

  task automatic window4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    step(1'b1, a);
    step(1'b1, b);
    step(1'b1, c);
    step(1'b1, d);
  endtask

  logic [7:0] ry;

  initial begin
    reset = 1'b0; en_i = 1'b0; vote_ready_i = 1'b1; y_valid_i = 1'b0; y_i = 8'h00;
    #2;
    chk("rst_vote_o", vote_o, 8'h00);
    chk("rst_vote_valid_o", vote_valid_o, 1'b0);
    chk("rst_start_o", start_o, 1'b0);
    chk("rst_err_o", err_o, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Plain majority with latency probe.
    en_i = 1'b1;
    step(1'b0, 8'h00);
    window4(8'h01, 8'h02, 8'h02, 8'h03);
    chk("lat_not_yet", vote_valid_o, 1'b0);
    step(1'b0, 8'h00);
    chk("lat_valid", vote_valid_o, 1'b1);
    chk("t1_vote", vote_o, 8'h02);
    chk("t1_err", err_o, 1'b0);
    step(1'b0, 8'h00);

    // Tie resolves to lowest code.
    window4(8'h01, 8'h01, 8'h03, 8'h03);
    step(1'b0, 8'h00);
    chk("t2_vote", vote_o, 8'h01);
    step(1'b0, 8'h00);

    // All invalid codes.
    window4(8'h00, 8'h05, 8'hFF, 8'h00);
    step(1'b0, 8'h00);
    chk("t3_vote", vote_o, 8'h00);
    chk("t3_err", err_o, 1'b1);
`ifdef VOTE_ERR_CNT_EN
    chk("t3_err_cnt", err_cnt_o, 16'd4);
`endif
    step(1'b0, 8'h00);

    // Held vote ignores samples; next window starts from zero.
    vote_ready_i = 1'b0;
    window4(8'h04, 8'h01, 8'h01, 8'h02);
    step(1'b0, 8'h00);
    repeat (10) begin
      step(1'b1, 8'h04);
      chk("t4_hold_vote", vote_o, 8'h01);
      chk("t4_hold_start", start_o, 1'b0);
      chk("t4_hold_valid", vote_valid_o, 1'b1);
    end
    vote_ready_i = 1'b1;
    step(1'b0, 8'h00);
    window4(8'h04, 8'h04, 8'h01, 8'h01);
    step(1'b0, 8'h00);
    chk("t4_next_vote", vote_o, 8'h01);
    step(1'b0, 8'h00);

    // Asynchronous reset mid-window.
    step(1'b1, 8'h03);
    step(1'b1, 8'h03);
    reset = 1'b0;
    #1;
    chk("t5_vote_o", vote_o, 8'h00);
    chk("t5_start_o", start_o, 1'b0);
    chk("t5_valid", vote_valid_o, 1'b0);
    chk("t5_err_o", err_o, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'h03);
    step(1'b1, 8'h03);
    step(1'b1, 8'h03);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("t5_partial_no_vote", vote_valid_o, 1'b0);
    step(1'b1, 8'h02);
    step(1'b0, 8'h00);
    chk("t5_vote", vote_o, 8'h03);
    step(1'b0, 8'h00);

    // Enable drop aborts the window.
    step(1'b1, 8'h02);
    step(1'b1, 8'h02);
    step(1'b1, 8'h02);
    en_i = 1'b0;
    step(1'b0, 8'h00);
    chk("t6_start_off", start_o, 1'b0);
    repeat (3) step(1'b1, 8'h02);
    chk("t6_no_vote", vote_valid_o, 1'b0);
    en_i = 1'b1;
    step(1'b0, 8'h00);
    window4(8'h01, 8'h01, 8'h02, 8'h03);
    step(1'b0, 8'h00);
    chk("t6_vote", vote_o, 8'h01);
    step(1'b0, 8'h00);

    // Randomised traffic.
    repeat (500) begin
      en_i         = ($urandom_range(0, 19) != 0);
      vote_ready_i = ($urandom_range(0, 3) != 0);
      ry           = 8'($urandom_range(0, 7));
      if (ry < 8'd6) ry = (ry % 8'd4) + 8'd1;
      else if (ry == 8'd6) ry = 8'h00;
      else ry = 8'($urandom_range(5, 255));
      step(1'($urandom_range(0, 1)), ry);
    end

    en_i = 1'b0;
    vote_ready_i = 1'b1;
    repeat (10) step(1'b0, 8'h00);
    chk("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
